// File: rtl/cafeteira_multidose.sv
// -----------------------------------------------------------------------------
// cafeteira_multidose
//
// Multi-dose coffee maker controller. A job serves `doses` cups (0 means one).
// Each dose runs: measure water level -> measure cup presence -> pump ->
// heat until the boiler reports temperature -> open the valve -> count.
// The two ultrasonic sensors are measured by pulsing their trigger and timing
// the width of the returned echo. A long water echo means the reservoir is
// empty and a long (or missing) cup echo means there is no cup; both park the
// controller in an error state until a new preparar edge retries the dose.
//
// Ports
//   clock, reset        : single clock domain, asynchronous active-high reset
//   preparar            : start/retry request (level, only the synchronized
//                         rising edge is acted upon; OCIOSO and error states
//                         are the only states that listen to it)
//   doses, modo         : job parameters, sampled once when a job starts
//   echo_agua           : water-level sensor echo (asynchronous)
//   echo_xicara         : cup sensor echo (asynchronous)
//   fim_temperatura     : boiler reached temperature (asynchronous)
//   trigger_agua/xicara : sensor trigger pulses, TRIG_CYC clocks long
//   bomba/ebulidor/valvula : pump, boiler, valve (at most one high at a time)
//   erro_sem_agua/xicara: error flags, held while in the matching error state
//   pronto              : controller idle
//   fim                 : one-cycle pulse when the last dose of a job is done
//   doses_feitas        : doses completed in the current job
// -----------------------------------------------------------------------------
module cafeteira_multidose #(
    parameter int DOSE_W            = 3,
    parameter int TRIG_CYC          = 500,
    parameter int ECHO_MAX_CYC      = 1_500_000,
    parameter int AGUA_LIMIAR_CYC   = 60_000,
    parameter int XICARA_LIMIAR_CYC = 30_000,
    parameter int BOMBA_CYC         = 50_000_000,
    parameter int VALV_CURTO_CYC    = 100_000_000,
    parameter int VALV_LONGO_CYC    = 200_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              preparar,
    input  logic [DOSE_W-1:0] doses,
    input  logic              modo,
    input  logic              echo_agua,
    input  logic              echo_xicara,
    input  logic              fim_temperatura,
    output logic              trigger_agua,
    output logic              trigger_xicara,
    output logic              bomba,
    output logic              ebulidor,
    output logic              valvula,
    output logic              erro_sem_agua,
    output logic              erro_sem_xicara,
    output logic              pronto,
    output logic              fim,
    output logic [DOSE_W-1:0] doses_feitas
);

    // One shared duration counter, wide enough for the largest duration or
    // threshold so that no count or comparison can wrap.
    localparam int MAX_1   = (TRIG_CYC > ECHO_MAX_CYC) ? TRIG_CYC : ECHO_MAX_CYC;
    localparam int MAX_2   = (MAX_1 > AGUA_LIMIAR_CYC) ? MAX_1 : AGUA_LIMIAR_CYC;
    localparam int MAX_3   = (MAX_2 > XICARA_LIMIAR_CYC) ? MAX_2 : XICARA_LIMIAR_CYC;
    localparam int MAX_4   = (MAX_3 > BOMBA_CYC) ? MAX_3 : BOMBA_CYC;
    localparam int MAX_5   = (MAX_4 > VALV_CURTO_CYC) ? MAX_4 : VALV_CURTO_CYC;
    localparam int MAX_CYC = (MAX_5 > VALV_LONGO_CYC) ? MAX_5 : VALV_LONGO_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX   = CNT_W'(ECHO_MAX_CYC);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ECHO_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] AGUA_LIM   = CNT_W'(AGUA_LIMIAR_CYC);
    localparam logic [CNT_W-1:0] XIC_LIM    = CNT_W'(XICARA_LIMIAR_CYC);
    localparam logic [CNT_W-1:0] BOMBA_LAST = CNT_W'(BOMBA_CYC - 1);
    localparam logic [CNT_W-1:0] CURTO_LAST = CNT_W'(VALV_CURTO_CYC - 1);
    localparam logic [CNT_W-1:0] LONGO_LAST = CNT_W'(VALV_LONGO_CYC - 1);

    typedef enum logic [3:0] {
        OCIOSO, MEDE_AGUA, MEDE_XICARA, BOMBEIA, AQUECE,
        SERVE, CONTA, ERRO_AGUA, ERRO_XICARA
    } state_t;

    // Sub-phases of a sensor measurement: trigger pulse, wait for the echo
    // to rise, then time the echo width.
    typedef enum logic [1:0] {PH_TRIG, PH_WAIT, PH_LARG} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DOSE_W-1:0]  req_q, req_d;
    logic [DOSE_W-1:0]  feitas_q, feitas_d;
    logic               modo_q, modo_d;

    logic [1:0]         agua_sync_q, agua_sync_d;
    logic [1:0]         xic_sync_q, xic_sync_d;
    logic [1:0]         temp_sync_q, temp_sync_d;
    logic [2:0]         prep_sync_q, prep_sync_d;

    logic               agua_s, xic_s, temp_s, prep_rise, echo_sel;
    logic [DOSE_W-1:0]  feitas_inc;
    logic [CNT_W-1:0]   valv_last;

    logic               meas_done;
    logic [CNT_W-1:0]   meas_width;
    phase_t             meas_phase_d;
    logic [CNT_W-1:0]   meas_cnt_d;

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------
    always_comb begin
        agua_sync_d = {agua_sync_q[0], echo_agua};
        xic_sync_d  = {xic_sync_q[0], echo_xicara};
        temp_sync_d = {temp_sync_q[0], fim_temperatura};
        prep_sync_d = {prep_sync_q[1:0], preparar};
    end

    assign agua_s     = agua_sync_q[1];
    assign xic_s      = xic_sync_q[1];
    assign temp_s     = temp_sync_q[1];
    // Third flop only serves the edge detector.
    assign prep_rise  = prep_sync_q[1] & ~prep_sync_q[2];
    assign echo_sel   = (state_q == MEDE_XICARA) ? xic_s : agua_s;
    assign feitas_inc = feitas_q + DOSE_W'(1);
    assign valv_last  = modo_q ? LONGO_LAST : CURTO_LAST;

    // ---------------------------------------------------------------------
    // Echo measurement. meas_width is only meaningful when meas_done is set.
    // A missing echo and a saturated echo both report ECHO_MAX.
    // ---------------------------------------------------------------------
    always_comb begin
        meas_done    = 1'b0;
        meas_width   = cnt_q;
        meas_phase_d = phase_q;
        meas_cnt_d   = cnt_q + CNT_W'(1);
        case (phase_q)
            PH_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    meas_phase_d = PH_WAIT;
                    meas_cnt_d   = '0;
                end
            end
            PH_WAIT: begin
                if (echo_sel) begin
                    // The first high sample already counts towards the width.
                    meas_phase_d = PH_LARG;
                    meas_cnt_d   = CNT_W'(1);
                end else if (cnt_q == WAIT_LAST) begin
                    meas_done  = 1'b1;
                    meas_width = ECHO_MAX;
                end
            end
            PH_LARG: begin
                if (!echo_sel) begin
                    meas_done  = 1'b1;
                    meas_width = cnt_q;
                end else if (cnt_q == ECHO_MAX) begin
                    meas_done  = 1'b1;
                    meas_width = ECHO_MAX;
                end
            end
            default: begin
                meas_phase_d = PH_TRIG;
                meas_cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= OCIOSO;
            phase_q     <= PH_TRIG;
            cnt_q       <= '0;
            req_q       <= '0;
            feitas_q    <= '0;
            modo_q      <= 1'b0;
            agua_sync_q <= '0;
            xic_sync_q  <= '0;
            temp_sync_q <= '0;
            prep_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            feitas_q    <= feitas_d;
            modo_q      <= modo_d;
            agua_sync_q <= agua_sync_d;
            xic_sync_q  <= xic_sync_d;
            temp_sync_q <= temp_sync_d;
            prep_sync_q <= prep_sync_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state. The counter returns to zero on every state change, so each
    // timed state starts counting from zero.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = '0;
        req_d    = req_q;
        feitas_d = feitas_q;
        modo_d   = modo_q;
        case (state_q)
            OCIOSO: begin
                if (prep_rise) begin
                    req_d    = (doses == '0) ? DOSE_W'(1) : doses;
                    modo_d   = modo;
                    feitas_d = '0;
                    phase_d  = PH_TRIG;
                    state_d  = MEDE_AGUA;
                end
            end
            MEDE_AGUA, MEDE_XICARA: begin
                phase_d = meas_phase_d;
                cnt_d   = meas_cnt_d;
                if (meas_done) begin
                    phase_d = PH_TRIG;
                    cnt_d   = '0;
                    if (state_q == MEDE_AGUA)
                        state_d = (meas_width > AGUA_LIM) ? ERRO_AGUA : MEDE_XICARA;
                    else
                        state_d = (meas_width >= XIC_LIM) ? ERRO_XICARA : BOMBEIA;
                end
            end
            BOMBEIA: begin
                if (cnt_q == BOMBA_LAST) state_d = AQUECE;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            AQUECE: begin
                if (temp_s) state_d = SERVE;
            end
            SERVE: begin
                if (cnt_q == valv_last) state_d = CONTA;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            CONTA: begin
                feitas_d = feitas_inc;
                phase_d  = PH_TRIG;
                state_d  = (feitas_inc == req_q) ? OCIOSO : MEDE_AGUA;
            end
            ERRO_AGUA, ERRO_XICARA: begin
                // Retry the current dose; completed doses are kept.
                if (prep_rise) begin
                    phase_d = PH_TRIG;
                    state_d = MEDE_AGUA;
                end
            end
            default: begin
                phase_d = PH_TRIG;
                state_d = OCIOSO;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: decoded straight from the registered state, so a reset drops
    // every actuator as soon as the state flops clear.
    // ---------------------------------------------------------------------
    always_comb begin
        trigger_agua    = 1'b0;
        trigger_xicara  = 1'b0;
        bomba           = 1'b0;
        ebulidor        = 1'b0;
        valvula         = 1'b0;
        erro_sem_agua   = 1'b0;
        erro_sem_xicara = 1'b0;
        pronto          = 1'b0;
        fim             = 1'b0;
        case (state_q)
            OCIOSO:      pronto          = 1'b1;
            MEDE_AGUA:   trigger_agua    = (phase_q == PH_TRIG);
            MEDE_XICARA: trigger_xicara  = (phase_q == PH_TRIG);
            BOMBEIA:     bomba           = 1'b1;
            AQUECE:      ebulidor        = 1'b1;
            SERVE:       valvula         = 1'b1;
            CONTA:       fim             = (feitas_inc == req_q);
            ERRO_AGUA:   erro_sem_agua   = 1'b1;
            ERRO_XICARA: erro_sem_xicara = 1'b1;
            default:     pronto          = 1'b0;
        endcase
    end

    assign doses_feitas = feitas_q;

endmodule

// File: tb/tb_cafeteira_multidose.sv
module tb_cafeteira_multidose;

    localparam int DOSE_W   = 3;
    localparam int TRIG     = 4;
    localparam int ECHO_MAX = 200;
    localparam int AGUA_LIM = 50;
    localparam int XIC_LIM  = 30;
    localparam int BOMBA    = 10;
    localparam int VCURTO   = 8;
    localparam int VLONGO   = 16;

    logic              clock;
    logic              reset;
    logic              preparar;
    logic [DOSE_W-1:0] doses;
    logic              modo;
    logic              echo_agua;
    logic              echo_xicara;
    logic              fim_temperatura;
    logic              trigger_agua;
    logic              trigger_xicara;
    logic              bomba;
    logic              ebulidor;
    logic              valvula;
    logic              erro_sem_agua;
    logic              erro_sem_xicara;
    logic              pronto;
    logic              fim;
    logic [DOSE_W-1:0] doses_feitas;

    cafeteira_multidose #(
        .DOSE_W(DOSE_W), .TRIG_CYC(TRIG), .ECHO_MAX_CYC(ECHO_MAX),
        .AGUA_LIMIAR_CYC(AGUA_LIM), .XICARA_LIMIAR_CYC(XIC_LIM),
        .BOMBA_CYC(BOMBA), .VALV_CURTO_CYC(VCURTO), .VALV_LONGO_CYC(VLONGO)
    ) dut (
        .clock(clock), .reset(reset), .preparar(preparar), .doses(doses),
        .modo(modo), .echo_agua(echo_agua), .echo_xicara(echo_xicara),
        .fim_temperatura(fim_temperatura), .trigger_agua(trigger_agua),
        .trigger_xicara(trigger_xicara), .bomba(bomba), .ebulidor(ebulidor),
        .valvula(valvula), .erro_sem_agua(erro_sem_agua),
        .erro_sem_xicara(erro_sem_xicara), .pronto(pronto), .fim(fim),
        .doses_feitas(doses_feitas)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- bookkeeping ----------------
    int vec_cnt = 0;
    int miscmp  = 0;
    int agua_w  = 20;   // echo width returned by the water sensor, 0 = none
    int xic_w   = 10;   // echo width returned by the cup sensor, 0 = none

    // Monitor-owned counters; the main sequence only reads them.
    int bomba_cnt = 0, valv_cnt = 0, fim_cnt = 0;
    int ta_run = 0, tx_run = 0, trig_bad = 0, excl_bad = 0;
    // Snapshots taken by the main sequence at job start.
    int b_bomba, b_valv, b_fim;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- environment models ----------------
    // Output monitor: actuator cycle counts, trigger lengths, exclusivity.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bomba)   bomba_cnt++;
                if (valvula) valv_cnt++;
                if (fim)     fim_cnt++;
                if (trigger_agua) ta_run++;
                else if (ta_run != 0) begin
                    if (ta_run != TRIG) trig_bad++;
                    ta_run = 0;
                end
                if (trigger_xicara) tx_run++;
                else if (tx_run != 0) begin
                    if (tx_run != TRIG) trig_bad++;
                    tx_run = 0;
                end
                if ((int'(bomba) + int'(ebulidor) + int'(valvula)) > 1 ||
                    (trigger_agua && trigger_xicara))
                    excl_bad++;
            end else begin
                ta_run = 0;
                tx_run = 0;
            end
        end
    end

    // Water sensor: after the trigger falls, echo for agua_w clocks.
    initial begin
        int n;
        echo_agua = 1'b0;
        forever begin
            @(negedge clock);
            if (trigger_agua && !reset) begin
                n = 0;
                while (trigger_agua && n < 1000) begin @(negedge clock); n++; end
                repeat (2) @(negedge clock);
                if (agua_w > 0) begin
                    echo_agua = 1'b1;
                    repeat (agua_w) @(negedge clock);
                    echo_agua = 1'b0;
                end
            end
        end
    end

    // Cup sensor.
    initial begin
        int n;
        echo_xicara = 1'b0;
        forever begin
            @(negedge clock);
            if (trigger_xicara && !reset) begin
                n = 0;
                while (trigger_xicara && n < 1000) begin @(negedge clock); n++; end
                repeat (2) @(negedge clock);
                if (xic_w > 0) begin
                    echo_xicara = 1'b1;
                    repeat (xic_w) @(negedge clock);
                    echo_xicara = 1'b0;
                end
            end
        end
    end

    // Boiler: reports temperature 5 clocks after heating starts.
    initial begin
        int heat;
        heat = 0;
        fim_temperatura = 1'b0;
        forever begin
            @(negedge clock);
            if (ebulidor) begin
                heat++;
                if (heat >= 5) fim_temperatura = 1'b1;
            end else begin
                heat = 0;
                fim_temperatura = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_prep();
        preparar = 1'b1;
        repeat (4) @(negedge clock);
        preparar = 1'b0;
    endtask

    task automatic start_job(input logic [DOSE_W-1:0] d, input logic m);
        doses   = d;
        modo    = m;
        b_bomba = bomba_cnt;
        b_valv  = valv_cnt;
        b_fim   = fim_cnt;
        pulse_prep();
    endtask

    task automatic wait_active(input string tag);
        int n = 0;
        while ((pronto || erro_sem_agua || erro_sem_xicara) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_started"}, (n < 20) ? 1 : 0, 1);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(pronto || erro_sem_agua || erro_sem_xicara) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ended_in_time"}, (n < 4000) ? 1 : 0, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_ok(input string tag, input int feitas, input int nb, input int nv);
        check({tag, "_pronto"},       int'(pronto), 1);
        check({tag, "_erro_agua"},    int'(erro_sem_agua), 0);
        check({tag, "_erro_xicara"},  int'(erro_sem_xicara), 0);
        check({tag, "_doses_feitas"}, int'(doses_feitas), feitas);
        check({tag, "_bomba_cyc"},    bomba_cnt - b_bomba, nb);
        check({tag, "_valvula_cyc"},  valv_cnt - b_valv, nv);
        check({tag, "_fim_pulses"},   fim_cnt - b_fim, 1);
    endtask

    task automatic check_err(input string tag, input int agua, input int feitas);
        check({tag, "_erro_agua"},    int'(erro_sem_agua), agua);
        check({tag, "_erro_xicara"},  int'(erro_sem_xicara), 1 - agua);
        check({tag, "_pronto"},       int'(pronto), 0);
        check({tag, "_doses_feitas"}, int'(doses_feitas), feitas);
        check({tag, "_outputs_off"},
              int'({bomba, ebulidor, valvula, trigger_agua, trigger_xicara, fim}), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DOSE_W-1:0] doses;
        logic              modo;
        int                agua_w;
        int                xic_w;
        int                exp_feitas;
        int                exp_bomba;
        int                exp_valv;
    } job_t;

    job_t tab[6];

    // ---------------- main sequence ----------------
    initial begin
        int n;
        tab[0] = '{3'd2, 1'b0, 20, 10, 2, 20, 16};
        tab[1] = '{3'd0, 1'b1, 20, 10, 1, 10, 16};
        tab[2] = '{3'd3, 1'b0, 20, 10, 3, 30, 24};
        tab[3] = '{3'd1, 1'b1, 50, 29, 1, 10, 16};
        tab[4] = '{3'd7, 1'b0,  5,  1, 7, 70, 56};
        tab[5] = '{3'd4, 1'b1, 20, 10, 4, 40, 64};

        reset    = 1'b1;
        preparar = 1'b0;
        doses    = '0;
        modo     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pronto", int'(pronto), 1);
        check("rst_outputs", int'({trigger_agua, trigger_xicara, bomba, ebulidor,
              valvula, erro_sem_agua, erro_sem_xicara, fim}), 0);
        check("rst_doses_feitas", int'(doses_feitas), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_pronto", int'(pronto), 1);

        // Table-driven complete jobs.
        for (int i = 0; i < 6; i++) begin
            agua_w = tab[i].agua_w;
            xic_w  = tab[i].xic_w;
            start_job(tab[i].doses, tab[i].modo);
            wait_active($sformatf("tab%0d", i));
            wait_end($sformatf("tab%0d", i));
            check_ok($sformatf("tab%0d", i), tab[i].exp_feitas, tab[i].exp_bomba,
                     tab[i].exp_valv);
        end

        // Empty reservoir, then retry with water.
        agua_w = 80; xic_w = 10;
        start_job(3'd1, 1'b0);
        wait_active("agua80");
        wait_end("agua80");
        repeat (10) @(negedge clock);
        check_err("agua80", 1, 0);
        check("agua80_bomba_cyc", bomba_cnt - b_bomba, 0);
        agua_w = 20;
        pulse_prep();
        wait_active("agua80_retry");
        wait_end("agua80_retry");
        check_ok("agua80_retry", 1, 10, 8);

        // Water width just above the threshold.
        agua_w = 51;
        start_job(3'd1, 1'b0);
        wait_active("agua51");
        wait_end("agua51");
        check_err("agua51", 1, 0);
        agua_w = 20;
        pulse_prep();
        wait_active("agua51_retry");
        wait_end("agua51_retry");
        check_ok("agua51_retry", 1, 10, 8);

        // Cup width exactly at the threshold.
        xic_w = 30;
        start_job(3'd2, 1'b1);
        wait_active("xic30");
        wait_end("xic30");
        check_err("xic30", 0, 0);
        xic_w = 29;
        pulse_prep();
        wait_active("xic30_retry");
        wait_end("xic30_retry");
        check_ok("xic30_retry", 2, 20, 32);

        // Three doses, cup missing (no echo) on the second.
        xic_w = 10;
        start_job(3'd3, 1'b0);
        n = 0;
        while (doses_feitas != 3'd1 && n < 2000) begin @(negedge clock); n++; end
        check("nocup_first_dose_in_time", (n < 2000) ? 1 : 0, 1);
        xic_w = 0;
        wait_end("nocup");
        check_err("nocup", 0, 1);
        xic_w = 10;
        pulse_prep();
        wait_active("nocup_retry");
        wait_end("nocup_retry");
        check_ok("nocup_retry", 3, 30, 24);

        // preparar edge and doses/modo changes during SERVE are ignored.
        start_job(3'd1, 1'b0);
        n = 0;
        while (!valvula && n < 2000) begin @(negedge clock); n++; end
        check("serve_reached", (n < 2000) ? 1 : 0, 1);
        doses = 3'd5;
        modo  = 1'b1;
        pulse_prep();
        wait_end("serve_prep");
        repeat (30) @(negedge clock);
        check_ok("serve_prep", 1, 10, 8);

        // Reset during the pump phase of the second dose.
        doses = 3'd2; modo = 1'b0;
        start_job(3'd2, 1'b0);
        n = 0;
        while (!(doses_feitas == 3'd1 && bomba) && n < 2000) begin @(negedge clock); n++; end
        check("rst_mid_bomba_reached", (n < 2000) ? 1 : 0, 1);
        check("rst_mid_bomba_on", int'(bomba), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_bomba_async", int'(bomba), 0);
        check("rst_mid_pronto", int'(pronto), 1);
        check("rst_mid_doses_feitas", int'(doses_feitas), 0);
        check("rst_mid_outputs", int'({trigger_agua, trigger_xicara, ebulidor,
              valvula, erro_sem_agua, erro_sem_xicara, fim}), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_mid_stays_idle", int'(pronto), 1);

        // Normal job after the reset.
        start_job(3'd1, 1'b1);
        wait_active("after_rst");
        wait_end("after_rst");
        check_ok("after_rst", 1, 10, 16);

        check("trigger_length_errors", trig_bad, 0);
        check("exclusivity_errors", excl_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
